// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the RV32I-subset datapath: per-state strobes and mux selects,
// stalling on mem_ready. Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes (adds the illegal port).
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic       instr_done
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    TRAP     = 4'd15
  } state_t;

  state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    // NOTE: every output and next state gets a default first, so no path infers a latch.
    state_d    = state_q;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    instr_done = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif

    // Strobes are gated by rst_n so an abandoned instruction issues no write.
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) state_d = DECODE;
        end
        DECODE: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b10;
          unique case (Opcode)
            OP_LOAD, OP_STORE: state_d = MEM_ADDR;
            OP_R:              state_d = EXEC_R;
            OP_I:              state_d = EXEC_I;
            OP_BRANCH:         state_d = BRANCH;
            OP_JAL:            state_d = JAL;
            OP_JALR:           state_d = JALR;
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
              state_d    = TRAP;
`else
              state_d    = FETCH;
              instr_done = 1'b1;
`endif
            end
          endcase
        end
        MEM_ADDR: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          state_d = (Opcode == OP_STORE) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = MEM_WB;
        end
        MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 2'b01;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) state_d = FETCH;
        end
        EXEC_R: begin
          ALUSrcA = 2'b01;
          ALUOp   = 2'b10;
          state_d = ALU_WB;
        end
        EXEC_I: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
          state_d = ALU_WB;
        end
        ALU_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          ALUSrcA    = 2'b01;
          ALUOp      = 2'b01;
          PCSource   = 2'b01;
          PCWrite    = Zero;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JAL: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b01;
          RegWrite   = 1'b1;
          MemtoReg   = 2'b10;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JALR: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          PCWrite    = 1'b1;
          RegWrite   = 1'b1;
          MemtoReg   = 2'b10;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        TRAP: begin
          illegal = 1'b1;
          state_d = TRAP;
        end
`endif
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state and packed control vector
// against hand-derived constants.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Opcode;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, instr_done;
  logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int tests = 0;
  int fails = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // Packed order: PCWrite IorD MemRead MemWrite IRWrite RegWrite MemtoReg ALUSrcA ALUSrcB ALUOp PCSource instr_done
  logic [16:0] ctrl;
  assign ctrl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

  localparam logic [16:0] C_ZERO     = 17'b0_0_0_0_0_0_00_00_00_00_00_0;
  localparam logic [16:0] C_FETCH    = 17'b1_0_1_0_1_0_00_00_01_00_00_0;
  localparam logic [16:0] C_FETCH_ST = 17'b0_0_1_0_0_0_00_00_01_00_00_0;
  localparam logic [16:0] C_DECODE   = 17'b0_0_0_0_0_0_00_10_10_00_00_0;
  localparam logic [16:0] C_DEC_NOP  = 17'b0_0_0_0_0_0_00_10_10_00_00_1;
  localparam logic [16:0] C_MEM_ADDR = 17'b0_0_0_0_0_0_00_01_10_00_00_0;
  localparam logic [16:0] C_MEM_RD   = 17'b0_1_1_0_0_0_00_00_00_00_00_0;
  localparam logic [16:0] C_MEM_WB   = 17'b0_0_0_0_0_1_01_00_00_00_00_1;
  localparam logic [16:0] C_MEM_WR   = 17'b0_1_0_1_0_0_00_00_00_00_00_1;
  localparam logic [16:0] C_MEM_WR_S = 17'b0_1_0_1_0_0_00_00_00_00_00_0;
  localparam logic [16:0] C_EXEC_R   = 17'b0_0_0_0_0_0_00_01_00_10_00_0;
  localparam logic [16:0] C_EXEC_I   = 17'b0_0_0_0_0_0_00_01_10_11_00_0;
  localparam logic [16:0] C_ALU_WB   = 17'b0_0_0_0_0_1_00_00_00_00_00_1;
  localparam logic [16:0] C_BR_T     = 17'b1_0_0_0_0_0_00_01_00_01_01_1;
  localparam logic [16:0] C_BR_NT    = 17'b0_0_0_0_0_0_00_01_00_01_01_1;
  localparam logic [16:0] C_JAL      = 17'b1_0_0_0_0_1_10_00_00_00_01_1;
  localparam logic [16:0] C_JALR     = 17'b1_0_0_0_0_1_10_01_10_00_00_1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one FSM cycle on the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_ctrl);
    @(negedge clk);
    check({tag, "_state"}, 32'(state), 32'(exp_state));
    check({tag, "_ctrl"},  32'(ctrl),  32'(exp_ctrl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; Opcode = 7'b0110011; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl",  32'(ctrl),  32'(C_ZERO));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // R-type: 0,1,6,8
    step("r0", 4'd0, C_FETCH);
    step("r1", 4'd1, C_DECODE);
    step("r2", 4'd6, C_EXEC_R);
    step("r3", 4'd8, C_ALU_WB);

    // Load with two stall cycles in MEM_RD: 7 cycles total
    Opcode = 7'b0000011;
    step("ld0", 4'd0, C_FETCH);
    step("ld1", 4'd1, C_DECODE);
    step("ld2", 4'd2, C_MEM_ADDR);
    mem_ready = 1'b0;
    step("ld3", 4'd3, C_MEM_RD);
    step("ld4", 4'd3, C_MEM_RD);
    mem_ready = 1'b1;
    step("ld5", 4'd3, C_MEM_RD);
    step("ld6", 4'd4, C_MEM_WB);

    // Store with one FETCH stall
    Opcode = 7'b0100011; mem_ready = 1'b0;
    step("st0", 4'd0, C_FETCH_ST);
    mem_ready = 1'b1;
    step("st1", 4'd0, C_FETCH);
    step("st2", 4'd1, C_DECODE);
    step("st3", 4'd2, C_MEM_ADDR);
    step("st4", 4'd5, C_MEM_WR);

    // I-ALU with mem_ready low outside memory states: must not stall
    Opcode = 7'b0010011;
    step("i0", 4'd0, C_FETCH);
    mem_ready = 1'b0;
    step("i1", 4'd1, C_DECODE);
    step("i2", 4'd7, C_EXEC_I);
    step("i3", 4'd8, C_ALU_WB);
    mem_ready = 1'b1;

    // Branch taken / not taken
    Opcode = 7'b1100011; Zero = 1'b1;
    step("bt0", 4'd0, C_FETCH);
    step("bt1", 4'd1, C_DECODE);
    step("bt2", 4'd9, C_BR_T);
    Zero = 1'b0;
    step("bn0", 4'd0, C_FETCH);
    step("bn1", 4'd1, C_DECODE);
    step("bn2", 4'd9, C_BR_NT);

    // JAL and JALR
    Opcode = 7'b1101111;
    step("jal0", 4'd0, C_FETCH);
    step("jal1", 4'd1, C_DECODE);
    step("jal2", 4'd10, C_JAL);
    Opcode = 7'b1100111;
    step("jalr0", 4'd0, C_FETCH);
    step("jalr1", 4'd1, C_DECODE);
    step("jalr2", 4'd11, C_JALR);

    // Reset pulsed while a store is stalled in MEM_WR
    Opcode = 7'b0100011;
    step("rs0", 4'd0, C_FETCH);
    step("rs1", 4'd1, C_DECODE);
    step("rs2", 4'd2, C_MEM_ADDR);
    mem_ready = 1'b0;
    step("rs3", 4'd5, C_MEM_WR_S);
    #1;
    check("rs_pre_memwrite", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_state", 32'(state), 32'd0);
    check("rs_ctrl",  32'(ctrl),  32'(C_ZERO));
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1; Opcode = 7'b0110011;
    step("rs4", 4'd0, C_FETCH);
    step("rs5", 4'd1, C_DECODE);
    step("rs6", 4'd6, C_EXEC_R);
    step("rs7", 4'd8, C_ALU_WB);

    // Unknown opcode
    Opcode = 7'b1111111;
    step("ill0", 4'd0, C_FETCH);
`ifdef MC_ILLEGAL_TRAP_EN
    step("ill1", 4'd1, C_DECODE);
    step("ill2", 4'd15, C_ZERO);
    check("ill_flag", 32'(illegal), 32'd1);
    step("ill3", 4'd15, C_ZERO);
`else
    step("ill1", 4'd1, C_DEC_NOP);
    step("ill2", 4'd0, C_FETCH);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
